// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encodings
// and the reserved-operation check used by the stages and the pipeline top.
package shifter_pkg;

   localparam logic [2:0] OP_ROL = 3'b000;
   localparam logic [2:0] OP_SLL = 3'b001;
   localparam logic [2:0] OP_ROR = 3'b010;
   localparam logic [2:0] OP_SRL = 3'b011;
   localparam logic [2:0] OP_SRA = 3'b100;

   // Encodings above SRA carry no shift meaning; their data passes through.
   function automatic logic is_reserved(input logic [2:0] op);
      return op > OP_SRA;
   endfunction

endpackage

// File: rtl/shifter_pipe_stage.sv
// One combinational step of the barrel shifter: shifts or rotates by the
// fixed amount AMT when enabled. The sign bit is the original operand MSB,
// carried down the pipe so later SRA steps still fill correctly.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int AMT   = 1
) (
   input  logic [WIDTH-1:0] data,
   input  logic             en,
   input  logic [2:0]       op,
   input  logic             sign,
   output logic [WIDTH-1:0] res
);

   logic [WIDTH-1:0] sign_fill;

   // Sign fill occupies the AMT top bits vacated by an arithmetic right shift.
   assign sign_fill = {WIDTH{sign}} << (WIDTH - AMT);

   // Select the shifted value for this stage's fixed amount, or pass through.
   always_comb begin
      res = data;
      if (en) begin
         case (op)
            OP_ROL:  res = (data << AMT) | (data >> (WIDTH - AMT));
            OP_SLL:  res = data << AMT;
            OP_ROR:  res = (data >> AMT) | (data << (WIDTH - AMT));
            OP_SRL:  res = data >> AMT;
            OP_SRA:  res = (data >> AMT) | sign_fill;
            default: res = data;
         endcase
      end
   end

endmodule

// File: rtl/shifter_pipe.sv
// Pipelined barrel shifter: one register stage per count bit, stage k applies
// a shift of 2^k when cnt[k] is set. Operations travel with their tag and an
// error flag marking reserved opcodes.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready/out_ready may depend on the other side; valid never
// depends on ready, and a stalled out_* holds every field stable until taken.
module shifter_pipe
   import shifter_pkg::*;
#(
   parameter  int WIDTH = 16,
   parameter  int TAGW  = 4,
   localparam int CW    = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [CW-1:0]    in_cnt,
   input  logic [2:0]       in_op,
   input  logic [TAGW-1:0]  in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [TAGW-1:0]  out_tag,
   output logic             out_err
);

   // Per-stage register contents, indexed by stage number.
   logic [CW-1:0]    v_q;
   logic [CW-1:0]    load;
   logic [WIDTH-1:0] d_q [CW];
   logic [CW-1:0]    c_q [CW];
   logic [2:0]       o_q [CW];
   logic [TAGW-1:0]  t_q [CW];
   logic             e_q [CW];
   logic             s_q [CW];

   // A stage may load unless it and every stage after it are full while the
   // consumer stalls; this is what lets bubbles collapse under back-pressure.
   always_comb begin : p_load
      logic full;
      full = 1'b1;
      load = '0;
      for (int k = CW - 1; k >= 0; k--) begin
         full    = full & v_q[k];
         load[k] = out_ready | ~full;
      end
   end

   assign in_ready = load[0];

   for (genvar k = 0; k < CW; k++) begin : g_stage
      logic             v_i, e_i, s_i;
      logic [WIDTH-1:0] d_i, d_s;
      logic [CW-1:0]    c_i;
      logic [2:0]       o_i;
      logic [TAGW-1:0]  t_i;

      logic             v_r, e_r, s_r;
      logic [WIDTH-1:0] d_r;
      logic [CW-1:0]    c_r;
      logic [2:0]       o_r;
      logic [TAGW-1:0]  t_r;

      if (k == 0) begin : g_head
         assign v_i = in_valid;
         assign d_i = in_data;
         assign c_i = in_cnt;
         assign o_i = in_op;
         assign t_i = in_tag;
         assign e_i = is_reserved(in_op);
         assign s_i = in_data[WIDTH-1];
      end else begin : g_tail
         assign v_i = v_q[k-1];
         assign d_i = d_q[k-1];
         assign c_i = c_q[k-1];
         assign o_i = o_q[k-1];
         assign t_i = t_q[k-1];
         assign e_i = e_q[k-1];
         assign s_i = s_q[k-1];
      end

      shift_stage #(
         .WIDTH (WIDTH),
         .AMT   (1 << k)
      ) u_shift (
         .data  (d_i),
         .en    (c_i[k]),
         .op    (o_i),
         .sign  (s_i),
         .res   (d_s)
      );

      // Stage register: flush kills the valid bit, payload only moves with a valid op.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            v_r <= 1'b0;
            d_r <= '0;
            c_r <= '0;
            o_r <= '0;
            t_r <= '0;
            e_r <= 1'b0;
            s_r <= 1'b0;
         end else if (flush) begin
            v_r <= 1'b0;
         end else if (load[k]) begin
            v_r <= v_i;
            if (v_i) begin
               d_r <= d_s;
               c_r <= c_i;
               o_r <= o_i;
               t_r <= t_i;
               e_r <= e_i;
               s_r <= s_i;
            end
         end
      end

      assign v_q[k] = v_r;
      assign d_q[k] = d_r;
      assign c_q[k] = c_r;
      assign o_q[k] = o_r;
      assign t_q[k] = t_r;
      assign e_q[k] = e_r;
      assign s_q[k] = s_r;
   end

   assign out_valid = v_q[CW-1];
   assign out_data  = d_q[CW-1];
   assign out_tag   = t_q[CW-1];
   assign out_err   = e_q[CW-1];

endmodule
